sseg_banner_scroller: RTL and testbench

Parametrised scrolling-message engine for the multiplexed seven-segment display path. Holds a window position over a MSG_LEN-character active-low segment message and outputs a WIN_LEN-digit registered window that scrolls on an internal prescaled tick. Supports wrap-around rotation, ping-pong bounce, manual stepping and hold. Sits between the message source and the display time-multiplexer.

---
 rtl/sseg_banner_pkg.sv | 19 +
 rtl/sseg_banner_scroller_tick_gen.sv | 33 +++
 rtl/sseg_banner_scroller.sv | 150 +++++++++++++++
 tb/tb_sseg_banner_scroller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_banner_pkg.sv
// Shared types and helpers for the seven-segment banner scroller.
// Mode encoding, blank glyph and modulo position wrap.
package sseg_banner_pkg;

    typedef enum logic [1:0] {
        BM_WRAP   = 2'd0,
        BM_BOUNCE = 2'd1,
        BM_STEP   = 2'd2,
        BM_HOLD   = 2'd3
    } banner_mode_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // p is at most 2n-2 at every call site, so one subtraction suffices
    function automatic int pos_wrap(input int p, input int n);
        return (p >= n) ? p - n : p;
    endfunction

endpackage

// File: rtl/sseg_banner_scroller_tick_gen.sv
// Scroll prescaler: counts 0..TICK_PER-1, flags terminal count.
// Used as a clock enable only; i_clr restarts the count.
module tick_gen #(
    parameter int TICK_PER = 20000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (TICK_PER > 2) ? $clog2(TICK_PER) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == CW'(TICK_PER - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (i_clr || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sseg_banner_scroller.sv
// Scrolling window over an active-low segment message (wrap/bounce/step/hold).
// Optional blink blanking when SSEG_BANNER_BLINK_EN is defined.
module sseg_banner_scroller
    import sseg_banner_pkg::*;
#(
    parameter int MSG_LEN   = 10,
    parameter int WIN_LEN   = 4,
    parameter int TICK_PER  = 20000000,
    parameter int START_POS = MSG_LEN - WIN_LEN
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic                          i_dir,
    input  logic [1:0]                    i_mode,
    input  logic                          i_step,
    input  logic                          i_load,
    input  logic [MSG_LEN-1:0][7:0]       i_data_n,
`ifdef SSEG_BANNER_BLINK_EN
    input  logic                          i_blink,
`endif
    output logic [WIN_LEN-1:0][7:0]       o_map_n,
    output logic [$clog2(MSG_LEN)-1:0]    o_pos,
    output logic                          o_tick
);

    localparam int PW   = $clog2(MSG_LEN);
    localparam int MAXB = MSG_LEN - WIN_LEN;

    localparam logic [PW-1:0] START_P = PW'(START_POS);
    localparam logic [PW-1:0] MAXB_P  = PW'(MAXB);

    logic [PW-1:0]            pos_q, pos_d;
    logic                     bdir_q, bdir_d;
    banner_mode_e             mode_q, mode;
    logic [WIN_LEN-1:0][7:0]  map_q, map_d;
    logic                     tick;
    logic                     move;
    logic                     b_entry;
    logic                     b_dir;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p,
                                          input logic up);
        int n;
        n = int'(p) + (up ? 1 : MSG_LEN - 1);
        return PW'(pos_wrap(n, MSG_LEN));
    endfunction

    tick_gen #(
        .TICK_PER (TICK_PER)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_load),
        .o_tick  (tick)
    );

    assign mode    = banner_mode_e'(i_mode);
    assign move    = tick & i_en;
    assign b_entry = (mode == BM_BOUNCE) && (mode_q != BM_BOUNCE);
    // a fresh bounce run follows i_dir even on its very first tick
    assign b_dir   = b_entry ? i_dir : bdir_q;

    always_comb begin
        pos_d  = pos_q;
        bdir_d = bdir_q;
        if (i_load) begin
            pos_d  = START_P;
            bdir_d = i_dir;
        end else begin
            unique case (mode)
                BM_WRAP: begin
                    if (move) pos_d = nxt(pos_q, i_dir);
                end
                BM_BOUNCE: begin
                    bdir_d = b_dir;
                    if (move) begin
                        if (MAXB_P == '0 && pos_q == '0) begin
                            pos_d = pos_q;
                        end else if (pos_q == MAXB_P && b_dir) begin
                            bdir_d = 1'b0;
                            pos_d  = pos_q - PW'(1);
                        end else if (pos_q == '0 && !b_dir) begin
                            bdir_d = 1'b1;
                            pos_d  = pos_q + PW'(1);
                        end else if (pos_q > MAXB_P) begin
                            pos_d = pos_q - PW'(1);
                        end else if (b_dir) begin
                            pos_d = pos_q + PW'(1);
                        end else begin
                            pos_d = pos_q - PW'(1);
                        end
                    end
                end
                BM_STEP: begin
                    if (i_step) pos_d = nxt(pos_q, i_dir);
                end
                BM_HOLD: begin
                    pos_d = pos_q;
                end
                default: begin
                    pos_d = pos_q;
                end
            endcase
        end
    end

`ifdef SSEG_BANNER_BLINK_EN
    logic phase_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q <= 1'b0;
        end else if (tick) begin
            phase_q <= ~phase_q;
        end
    end
`endif

    always_comb begin
        map_d = '0;
        for (int k = 0; k < WIN_LEN; k++) begin
            map_d[k] = i_data_n[PW'(pos_wrap(int'(pos_q) + k, MSG_LEN))];
        end
`ifdef SSEG_BANNER_BLINK_EN
        if (i_blink && phase_q) begin
            map_d = {WIN_LEN{SEG_BLANK}};
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pos_q  <= START_P;
            bdir_q <= 1'b1;
            mode_q <= BM_WRAP;
            map_q  <= {WIN_LEN{SEG_BLANK}};
        end else begin
            pos_q  <= pos_d;
            bdir_q <= bdir_d;
            mode_q <= mode;
            map_q  <= map_d;
        end
    end

    assign o_map_n = map_q;
    assign o_pos   = pos_q;
    assign o_tick  = tick;

endmodule

// File: tb/tb_sseg_banner_scroller.sv
// Bench for sseg_banner_scroller: directed scenarios plus random
// stimulus against a modulo-arithmetic reference model.
module tb_sseg_banner_scroller;

    localparam int N    = 10;
    localparam int W    = 4;
    localparam int TP   = 4;
    localparam int SP   = N - W;
    localparam int MAXB = N - W;
    localparam logic [W*8-1:0] BLANK = '1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             en    = 1'b0;
    logic             dir   = 1'b1;
    logic [1:0]       mode  = 2'd0;
    logic             step  = 1'b0;
    logic             load  = 1'b0;
    logic [N-1:0][7:0] data;
    logic [W-1:0][7:0] map;
    logic [3:0]       pos;
    logic             tick;

    int n_tests = 0;
    int n_fail  = 0;

    int mpos, mbdir, mcnt, mprev;
    logic [W-1:0][7:0] mmap;

    always #5 clk = ~clk;

    sseg_banner_scroller #(
        .MSG_LEN  (N),
        .WIN_LEN  (W),
        .TICK_PER (TP)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_dir    (dir),
        .i_mode   (mode),
        .i_step   (step),
        .i_load   (load),
        .i_data_n (data),
        .o_map_n  (map),
        .o_pos    (pos),
        .o_tick   (tick)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        mpos  = SP;
        mbdir = 1;
        mcnt  = 0;
        mprev = 0;
        mmap  = BLANK;
    endtask

    task automatic mupdate();
        logic [W-1:0][7:0] nm;
        bit t, entry;
        int d;
        t = (mcnt == TP - 1);
        for (int k = 0; k < W; k++) nm[k] = data[(mpos + k) % N];
        entry = (mode == 2'd1) && (mprev != 1);
        if (load) begin
            mpos  = SP;
            mbdir = dir;
            mcnt  = 0;
        end else begin
            case (mode)
                2'd0: if (t && en) mpos = dir ? (mpos + 1) % N : (mpos + N - 1) % N;
                2'd1: begin
                    d = entry ? int'(dir) : mbdir;
                    if (t && en) begin
                        if (mpos > MAXB) mpos--;
                        else if (d == 1) begin
                            if (mpos == MAXB) begin d = 0; mpos--; end
                            else mpos++;
                        end else begin
                            if (mpos == 0) begin d = 1; mpos++; end
                            else mpos--;
                        end
                    end
                    mbdir = d;
                end
                2'd2: if (step) mpos = dir ? (mpos + 1) % N : (mpos + N - 1) % N;
                default: ;
            endcase
            mcnt = (mcnt + 1) % TP;
        end
        mprev = mode;
        mmap  = nm;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) mreset();
        else mupdate();
        #1;
        chk("pos", pos, mpos);
        chk("tick", tick, mcnt == TP - 1);
        chk("map", map, mmap);
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 mreset();
        chk("rst_pos", pos, SP);
        chk("rst_map", map, BLANK);
        chk("rst_tick", tick, 0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int hp;
        for (int i = 0; i < N; i++) data[i] = 8'($urandom);
        mreset();
        #12;
        chk("rst_pos", pos, SP);
        chk("rst_map", map, BLANK);
        chk("rst_tick", tick, 0);
        en = 1'b1;
        dir = 1'b1;
        mode = 2'd0;
        rst_n = 1'b1;

        repeat (4) cyc();
        chk("wrap_pos7", pos, 7);
        cyc();
        chk("win_at7", map, {data[0], data[9], data[8], data[7]});
        repeat (11) cyc();
        chk("wrap_pos0", pos, 0);
        dir = 1'b0;
        repeat (4) cyc();
        chk("wrap_pos9", pos, 9);
        cyc();
        chk("win_at9", map, {data[2], data[1], data[0], data[9]});

        for (int i = 0; i < 2 * TP && !tick; i++) cyc();
        chk("tick_seen", tick, 1);
        load = 1'b1;
        cyc();
        load = 1'b0;
        chk("load_pos", pos, SP);
        for (int i = 0; i < TP; i++) begin
            cyc();
            chk("tick_gap", tick, i == TP - 2);
        end
        cyc();
        pulse_reset();

        mode = 2'd2;
        dir = 1'b1;
        repeat (3) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            repeat (3) cyc();
        end
        chk("step_pos9", pos, 9);
        dir = 1'b0;
        repeat (5) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            cyc();
        end
        chk("step_pos4", pos, 4);

        mode = 2'd1;
        dir = 1'b1;
        repeat (60) begin
            cyc();
            chk("bounce_max", pos <= MAXB, 1);
        end

        mode = 2'd3;
        hp = mpos;
        repeat (40) begin
            cyc();
            chk("hold", pos, hp);
        end

        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            step = ($urandom_range(0, 3) == 0);
            load = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0)
                data[$urandom_range(0, N - 1)] = 8'($urandom);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
